// File: rtl/red_pitaya_daisy_loopback.sv
// Daisy-chain far-end loopback: buffers received 16-bit words in a FIFO and retransmits them paced by GAP_CYC.
// Optional macro DAISY_LB_ZERO_DROP_EN: zero words are discarded at the FIFO input.
module red_pitaya_daisy_loopback #(
  parameter int unsigned AW      = 4,
  parameter int unsigned GAP_CYC = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          lb_en_i,
  input  logic          rx_dv_i,
  input  logic [15:0]   rx_dat_i,
  input  logic          tx_rdy_i,
  output logic          tx_dv_o,
  output logic [15:0]   tx_dat_o,
  input  logic          stat_clr_i,
  output logic [31:0]   stat_fwd_o,
  output logic [31:0]   stat_ovf_o,
  output logic [AW:0]   fill_o
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          tx_dv_q, tx_dv_d;
  logic [15:0]   tx_dat_q, tx_dat_d;
  logic [31:0]   fwd_q, fwd_d;
  logic [31:0]   ovf_q, ovf_d;
  logic [15:0]   mem_q [DEPTH];

  logic [AW:0] fill;
  logic        empty, full, rx_ok, push, pop, fwd_inc, ovf_inc;

  assign fill  = wr_ptr_q - rd_ptr_q;
  assign empty = (fill == '0);
  assign full  = (fill == (AW+1)'(DEPTH));

`ifdef DAISY_LB_ZERO_DROP_EN
  assign rx_ok = rx_dv_i & lb_en_i & (rx_dat_i != 16'h0000);
`else
  assign rx_ok = rx_dv_i & lb_en_i;
`endif

  // Full is judged on the registered occupancy, so a same-cycle pop never rescues a write.
  assign push    = rx_ok & ~full;
  assign ovf_inc = rx_ok & full;
  assign pop     = lb_en_i & (state_q == IDLE) & ~empty & tx_rdy_i;
  assign fwd_inc = (state_q == SEND);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    tx_dv_d   = 1'b0;
    tx_dat_d  = tx_dat_q;
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d  = SEND;
          tx_dv_d  = 1'b1;
          tx_dat_d = mem_q[rd_ptr_q[AW-1:0]];
        end
      end
      SEND: begin
        state_d   = (GAP_CYC > 0) ? GAP : IDLE;
        gap_cnt_d = '0;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Disabling the link flushes the FIFO and idles TX; a SEND in flight still counts.
    if (!lb_en_i) begin
      state_d  = IDLE;
      tx_dv_d  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    // An increment in the same cycle wins over the clear.
    if (fwd_inc)         fwd_d = fwd_q + 32'd1;
    else if (stat_clr_i) fwd_d = '0;
    else                 fwd_d = fwd_q;

    if (ovf_inc)         ovf_d = ovf_q + 32'd1;
    else if (stat_clr_i) ovf_d = '0;
    else                 ovf_d = ovf_q;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst_i) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_dv_q   <= 1'b0;
      tx_dat_q  <= '0;
      fwd_q     <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_dv_q   <= tx_dv_d;
      tx_dat_q  <= tx_dat_d;
      fwd_q     <= fwd_d;
      ovf_q     <= ovf_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_dat_i;
  end

  assign tx_dv_o    = tx_dv_q;
  assign tx_dat_o   = tx_dat_q;
  assign stat_fwd_o = fwd_q;
  assign stat_ovf_o = ovf_q;
  assign fill_o     = fill;

endmodule

// File: tb/tb_red_pitaya_daisy_loopback.sv
// Directed self-checking bench for red_pitaya_daisy_loopback (AW=4, GAP_CYC=3).
// Honours DAISY_LB_ZERO_DROP_EN for the zero-word step.
module tb_red_pitaya_daisy_loopback;

  localparam int AW      = 4;
  localparam int GAP_CYC = 3;
  localparam int PERIOD  = GAP_CYC + 2;  // SEND + GAP_CYC gap cycles + IDLE decision cycle

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          lb_en_i;
  logic          rx_dv_i;
  logic [15:0]   rx_dat_i;
  logic          tx_rdy_i;
  logic          tx_dv_o;
  logic [15:0]   tx_dat_o;
  logic          stat_clr_i;
  logic [31:0]   stat_fwd_o;
  logic [31:0]   stat_ovf_o;
  logic [AW:0]   fill_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;
  logic [15:0] words[$];
  int          wcyc[$];

  red_pitaya_daisy_loopback #(.AW(AW), .GAP_CYC(GAP_CYC)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lb_en_i    (lb_en_i),
    .rx_dv_i    (rx_dv_i),
    .rx_dat_i   (rx_dat_i),
    .tx_rdy_i   (tx_rdy_i),
    .tx_dv_o    (tx_dv_o),
    .tx_dat_o   (tx_dat_o),
    .stat_clr_i (stat_clr_i),
    .stat_fwd_o (stat_fwd_o),
    .stat_ovf_o (stat_ovf_o),
    .fill_o     (fill_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (tx_dv_o === 1'b1) begin
      pulses <= pulses + 1;
      words.push_back(tx_dat_o);
      wcyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  int base;
  int n0;

  initial begin
    rst_i = 1'b1; lb_en_i = 1'b0; rx_dv_i = 1'b0; rx_dat_i = '0;
    tx_rdy_i = 1'b0; stat_clr_i = 1'b0;
    tick(2);
    rst_i = 1'b0;
    check("rst_tx_dv",  32'(tx_dv_o),  32'd0);
    check("rst_tx_dat", 32'(tx_dat_o), 32'd0);
    check("rst_fwd",    stat_fwd_o,    32'd0);
    check("rst_ovf",    stat_ovf_o,    32'd0);
    check("rst_fill",   32'(fill_o),   32'd0);

    // Single word: pulse appears after the second edge.
    lb_en_i = 1'b1; tx_rdy_i = 1'b1;
    rx_dv_i = 1'b1; rx_dat_i = 16'hA5C3;
    tick();
    rx_dv_i = 1'b0;
    check("one_fill_t",  32'(fill_o),  32'd1);
    check("one_dv_t",    32'(tx_dv_o), 32'd0);
    tick();
    check("one_dv_t1",   32'(tx_dv_o),  32'd1);
    check("one_dat_t1",  32'(tx_dat_o), 32'hA5C3);
    check("one_fill_t1", 32'(fill_o),   32'd0);
    tick();
    check("one_dv_t2",   32'(tx_dv_o), 32'd0);
    check("one_fwd",     stat_fwd_o,   32'd1);
    tick(4);
    check("one_pulses",  32'(pulses),  32'd1);
    check("one_dat_hold", 32'(tx_dat_o), 32'hA5C3);

    // Six more words bring stat_fwd_o to 7.
    for (int i = 0; i < 6; i++) begin
      rx_dv_i = 1'b1; rx_dat_i = 16'(16'h0100 + i);
      tick();
    end
    rx_dv_i = 1'b0;
    tick(40);
    check("seven_fwd",  stat_fwd_o,  32'd7);
    check("seven_fill", 32'(fill_o), 32'd0);

    // Clear coincident with a SEND exit: the increment wins.
    rx_dv_i = 1'b1; rx_dat_i = 16'h0BEE;
    tick();
    rx_dv_i = 1'b0;
    tick();
    check("clr_dv",  32'(tx_dv_o), 32'd1);
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    check("clr_fwd_inc", stat_fwd_o, 32'd8);
    check("clr_ovf_inc", stat_ovf_o, 32'd0);
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    check("clr_fwd_zero", stat_fwd_o, 32'd0);
    tick(5);

    // Burst of 20 with TX stalled: 16 stored, 4 dropped.
    tx_rdy_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      rx_dv_i = 1'b1; rx_dat_i = 16'(i);
      tick();
    end
    rx_dv_i = 1'b0;
    check("burst_fill", 32'(fill_o),  32'd16);
    check("burst_ovf",  stat_ovf_o,   32'd4);
    check("burst_dv",   32'(tx_dv_o), 32'd0);

    // Full FIFO, push and pop in the same cycle: push dropped.
    base = words.size();
    tx_rdy_i = 1'b1; rx_dv_i = 1'b1; rx_dat_i = 16'h0099;
    tick();
    rx_dv_i = 1'b0;
    check("fullpop_ovf",  stat_ovf_o,    32'd5);
    check("fullpop_fill", 32'(fill_o),   32'd15);
    check("fullpop_dv",   32'(tx_dv_o),  32'd1);
    check("fullpop_dat",  32'(tx_dat_o), 32'd1);
    tick(16 * PERIOD + 5);
    check("drain_count", 32'(words.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < words.size()) begin
        check($sformatf("drain_word%0d", i), 32'(words[base + i]), 32'(i + 1));
        if (i > 0)
          check($sformatf("drain_gap%0d", i), 32'(wcyc[base + i] - wcyc[base + i - 1]), 32'(PERIOD));
      end
    end
    check("drain_fwd",  stat_fwd_o,  32'd16);
    check("drain_fill", 32'(fill_o), 32'd0);

    // Flush: five words buffered, one cycle of lb_en_i=0.
    tx_rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_dv_i = 1'b1; rx_dat_i = 16'(16'hCAF0 + i);
      tick();
    end
    check("flush_fill_pre", 32'(fill_o), 32'd5);
    lb_en_i = 1'b0; rx_dat_i = 16'h1234;
    tick();
    check("flush_fill", 32'(fill_o),  32'd0);
    check("flush_dv",   32'(tx_dv_o), 32'd0);
    rx_dv_i = 1'b0; lb_en_i = 1'b1; tx_rdy_i = 1'b1;
    n0 = pulses;
    tick(10);
    check("flush_pulses", 32'(pulses - n0), 32'd0);
    check("flush_fwd",    stat_fwd_o,       32'd16);
    check("flush_ovf",    stat_ovf_o,       32'd5);

    // Plain clear with no increments pending.
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    check("clr2_fwd", stat_fwd_o, 32'd0);
    check("clr2_ovf", stat_ovf_o, 32'd0);

    // Zero word.
    n0 = pulses;
    rx_dv_i = 1'b1; rx_dat_i = 16'h0000;
    tick();
    rx_dv_i = 1'b0;
`ifdef DAISY_LB_ZERO_DROP_EN
    check("zero_fill_t", 32'(fill_o), 32'd0);
    tick();
    check("zero_dv", 32'(tx_dv_o), 32'd0);
    tick(6);
    check("zero_fwd",    stat_fwd_o,       32'd0);
    check("zero_ovf",    stat_ovf_o,       32'd0);
    check("zero_pulses", 32'(pulses - n0), 32'd0);
`else
    check("zero_fill_t", 32'(fill_o), 32'd1);
    tick();
    check("zero_dv",  32'(tx_dv_o),  32'd1);
    check("zero_dat", 32'(tx_dat_o), 32'd0);
    tick(6);
    check("zero_fwd",    stat_fwd_o,       32'd1);
    check("zero_pulses", 32'(pulses - n0), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
